ws2812_pixel_feeder: RTL and testbench
======================================

Name: ws2812_pixel_feeder

Overview:
Upstream stage of the WS2812 serial driver. Holds a host-writable RGB pixel buffer of LED_NUM entries and applies a global brightness scale. Reorders each pixel to the WS2812 GRB wire order and streams one 24-bit word per LED to the driver over a valid/ready handshake. Frames start on an explicit request or on an internal refresh timer.

Parameters:
LED_NUM, 8, number of LEDs in the chain (1..256)
ADDR_W, 8, pixel address width; LED_NUM <= 2**ADDR_W
CLK_FRE, 27_000_000, clk frequency in Hz
REFRESH_HZ, 30, automatic frame rate; timer period = CLK_FRE/REFRESH_HZ cycles

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  host pixel write strobe
wr_addr  in  ADDR_W  pixel index to write
wr_rgb  in  24  pixel colour: R[23:16] G[15:8] B[7:0]
brightness  in  8  global brightness, 255 = full scale
frame_req  in  1  one-cycle pulse: start a frame
pix_data  out  24  scaled pixel to driver: G[23:16] R[15:8] B[7:0]
pix_valid  out  1  pix_data is valid
pix_ready  in  1  driver accepts pix_data this cycle
pix_last  out  1  pix_data is the final pixel (index LED_NUM-1) of the frame
busy  out  1  frame in progress (any state other than IDLE)

Behaviour:
- Reset (async, rst_n=0): pix_valid=0, pix_last=0, pix_data=0, busy=0, state=IDLE, pixel index=0, pending=0, refresh timer=0, all buffer entries=24'h0.
- Buffer: register array written on posedge when wr_en=1 and wr_addr<LED_NUM. Writes with wr_addr>=LED_NUM are ignored. Writes are accepted in every state.
- Refresh timer: free-running counter 0..CLK_FRE/REFRESH_HZ-1; wrapping generates a tick.
- Frame trigger = frame_req OR tick.
  - In IDLE: start a frame next cycle.
  - While busy: set pending (single flag; extra triggers merge).
  - On frame end with pending=1: clear pending, go straight to FETCH for the new frame with no IDLE cycle.
- At frame start, latch brightness into scale_q; it stays constant for the whole frame.
- FSM:
  - IDLE -> FETCH on trigger; index=0.
  - FETCH: read buffer[index] into pixel register -> SCALE.
  - SCALE: each channel out = (ch * (scale_q+1)) >> 8, 8x9-bit product, keep bits [15:8]. Reorder to GRB and register into pix_data. Set pix_valid=1 and pix_last=(index==LED_NUM-1) -> PRESENT.
  - PRESENT: hold pix_data/pix_valid/pix_last stable while pix_ready=0. On pix_valid&pix_ready: pix_valid=0, pix_last=0. If last: -> IDLE, or -> FETCH if pending. Else: index+1, -> FETCH.
- Timing:
  - Latency: trigger cycle t -> pix_valid high at t+3.
  - Handshake at cycle t -> next pix_valid at t+3.
  - pix_valid is never asserted outside PRESENT.
- Write vs. read hazard:
  - A write to an index not yet fetched in the current frame appears in this frame.
  - A write to an already-fetched index appears next frame.
  - A write and FETCH to the same index in the same cycle: FETCH reads the old value.
- Scale endpoints: brightness=255 is the identity; brightness=0 drives every channel to 0.
- pix_ready while pix_valid=0 is ignored.
- Reset mid-frame: outputs clear immediately (asynchronous); no partial frame resumes.

Test Plan:
1. Reset, write idx0=FF0000, idx1=00FF00, idx2=0000FF, brightness=255, pulse frame_req, pix_ready held 1 -> pix_data sequence 00FF00, FF0000, 0000FF, then 000000 for idx3..7. pix_last only on the 8th word. First pix_valid 3 cycles after frame_req.
2. brightness=127, idx0=C86432 (R=C8 G=64 B=32) -> pix_data=326419 (G=0x64*128>>8=0x32, R=0x64, B=0x19). brightness=0 -> 000000.
3. Backpressure: pix_ready=0 for 20 cycles while valid -> pix_data/pix_last unchanged, no index advance. Release -> exactly one transfer, then the next word 3 cycles later.
4. frame_req pulsed three times mid-frame -> exactly one extra frame, starting with FETCH the cycle after the last handshake. busy stays 1 across the boundary.
5. Refresh timer: CLK_FRE=3000, REFRESH_HZ=10, no frame_req -> a frame starts every 300 cycles. Writes to wr_addr=LED_NUM are ignored (buffer read back unchanged).
6. Assert rst_n low during PRESENT of pixel 4 -> pix_valid/busy drop immediately. After release, idle with no valid until the next trigger; buffer reads back 0.

Source files
------------

// File: rtl/ws2812_pixel_feeder.sv
// ws2812_pixel_feeder: RGB pixel buffer with brightness scaling, streamed as GRB words to a WS2812 driver
module ws2812_pixel_feeder #(
    parameter int LED_NUM    = 8,
    parameter int ADDR_W     = 8,
    parameter int CLK_FRE    = 27_000_000,
    parameter int REFRESH_HZ = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_rgb,
    input  logic [7:0]        brightness,
    input  logic              frame_req,
    output logic [23:0]       pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy
);
    localparam int PERIOD = CLK_FRE / REFRESH_HZ;
    localparam int TMR_W  = PERIOD > 1 ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, SCALE, PRESENT} state_t;

    state_t            state, state_d;
    logic [23:0]       pix_buf [LED_NUM];
    logic [23:0]       rd_rgb;
    logic [23:0]       pix_q;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        scale_q;
    logic [TMR_W-1:0]  tmr;
    logic              pending;
    logic              tick, trig, is_last, xfer, frame_end, start;

    // (ch * (s + 1)) >> 8 so that 255 is identity and 0 blanks the channel
    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] s);
        return 8'((17'(ch) * 17'({1'b0, s} + 9'd1)) >> 8);
    endfunction

    assign tick      = tmr == TMR_W'(PERIOD - 1);
    assign trig      = frame_req | tick;
    assign is_last   = idx == ADDR_W'(LED_NUM - 1);
    assign xfer      = state == PRESENT && pix_ready;
    assign frame_end = xfer && is_last;
    assign start     = (state == IDLE && trig) || (frame_end && (pending || trig));
    assign busy      = state != IDLE;

    // Host writes land in any state; out-of-range addresses match no entry
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < LED_NUM; i++) pix_buf[i] <= '0;
        else if (wr_en)
            for (int i = 0; i < LED_NUM; i++)
                if (wr_addr == ADDR_W'(i)) pix_buf[i] <= wr_rgb;

    // Buffer read port for FETCH
    always_comb begin
        rd_rgb = '0;
        for (int i = 0; i < LED_NUM; i++)
            if (idx == ADDR_W'(i)) rd_rgb = pix_buf[i];
    end

    // Free-running refresh timer; its wrap is the automatic frame trigger
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tmr <= '0;
        else        tmr <= tick ? '0 : tmr + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    // Next state: a frame end chains straight into FETCH when another frame is owed
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = trig ? FETCH : IDLE;
            FETCH:   state_d = SCALE;
            SCALE:   state_d = PRESENT;
            PRESENT: state_d = !pix_ready ? PRESENT : (is_last && !(pending || trig)) ? IDLE : FETCH;
        endcase
    end

    // Datapath: index, pending merge, brightness latch, fetch, scale/reorder, handshake
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx       <= '0;
            pending   <= 1'b0;
            scale_q   <= '0;
            pix_q     <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
        end else begin
            pending <= frame_end ? 1'b0 : pending | (trig & busy);
            if (start) begin
                idx     <= '0;
                scale_q <= brightness;
            end else if (xfer) begin
                idx <= idx + 1'b1;
            end
            if (state == FETCH) pix_q <= rd_rgb;
            if (state == SCALE) begin
                pix_data  <= {scale_ch(pix_q[15:8], scale_q), scale_ch(pix_q[23:16], scale_q),
                              scale_ch(pix_q[7:0], scale_q)};
                pix_valid <= 1'b1;
                pix_last  <= is_last;
            end else if (xfer) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end
        end
endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// tb_ws2812_pixel_feeder: directed tests of the WS2812 pixel feeder
module tb_ws2812_pixel_feeder;
    logic        clk = 0, rst_n = 0, wr_en = 0, frame_req = 0, pix_ready = 0;
    logic [7:0]  wr_addr = 0, brightness = 0;
    logic [23:0] wr_rgb = 0;
    logic [23:0] pix_data, pix_data2;
    logic        pix_valid, pix_last, busy, pix_valid2, pix_last2, busy2;
    int          total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_pixel_feeder #(.LED_NUM(8), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
        .brightness(brightness), .frame_req(frame_req), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last), .busy(busy));

    ws2812_pixel_feeder #(.LED_NUM(8), .ADDR_W(8), .CLK_FRE(3000), .REFRESH_HZ(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
        .brightness(brightness), .frame_req(1'b0), .pix_data(pix_data2),
        .pix_valid(pix_valid2), .pix_ready(1'b1), .pix_last(pix_last2), .busy(busy2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [23:0] d);
        wr_en = 1; wr_addr = a; wr_rgb = d;
        step();
        wr_en = 0;
    endtask

    task automatic pulse_req();
        frame_req = 1;
        step();
        frame_req = 0;
    endtask

    task automatic get_word(output logic [23:0] d, output logic l, output int w);
        w = 0;
        while (!pix_valid && w < 20) begin
            step();
            w++;
        end
        d = pix_data;
        l = pix_last;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) step();
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pix_valid); end
        total++; if (pix_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", pix_last); end
        total++; if (pix_data !== 24'h0) begin bad++; $display("FAIL reset_data: got %h want 000000", pix_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1;
        step();
    endtask

    task automatic test_basic();
        logic [23:0] exp [8];
        logic [23:0] d; logic l; int w;
        exp = '{24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        wr(0, 24'hFF0000); wr(1, 24'h00FF00); wr(2, 24'h0000FF);
        brightness = 255; pix_ready = 1;
        pulse_req();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start: got %b want 1", busy); end
        for (int k = 0; k < 8; k++) begin
            get_word(d, l, w);
            total++; if (w !== 2) begin bad++; $display("FAIL basic_latency[%0d]: got %0d want 2", k, w); end
            total++; if (d !== exp[k]) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", k, d, exp[k]); end
            total++; if (l !== (k == 7)) begin bad++; $display("FAIL basic_last[%0d]: got %b want %b", k, l, k == 7); end
            step();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_scale();
        logic [23:0] exp [8];
        logic [23:0] d; logic l; int w;
        exp = '{24'h326419, 24'h7F0000, 24'h00007F, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        wr(0, 24'hC86432);
        brightness = 127;
        pulse_req();
        for (int k = 0; k < 8; k++) begin
            get_word(d, l, w);
            if (k == 0) brightness = 255;
            total++; if (d !== exp[k] || w !== 2) begin bad++; $display("FAIL scale127_data[%0d]: got %h (lat %0d) want %h (lat 2)", k, d, w, exp[k]); end
            step();
        end
        brightness = 0;
        pulse_req();
        for (int k = 0; k < 8; k++) begin
            get_word(d, l, w);
            total++; if (d !== 24'h0 || l !== (k == 7)) begin bad++; $display("FAIL scale0_data[%0d]: got %h last %b want 000000 last %b", k, d, l, k == 7); end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] exp [8];
        logic [23:0] d; logic l; int w, changes;
        exp = '{24'h64C832, 24'hFF0000, 24'h0000FF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        brightness = 255; pix_ready = 0;
        pulse_req();
        get_word(d, l, w);
        total++; if (d !== exp[0] || w !== 2) begin bad++; $display("FAIL bp_first: got %h (lat %0d) want %h (lat 2)", d, w, exp[0]); end
        changes = 0;
        repeat (20) begin
            step();
            if (pix_valid !== 1'b1 || pix_data !== exp[0] || pix_last !== 1'b0) changes++;
        end
        total++; if (changes !== 0) begin bad++; $display("FAIL bp_hold: got %0d changed cycles want 0", changes); end
        pix_ready = 1;
        step();
        pix_ready = 0;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", pix_valid); end
        get_word(d, l, w);
        total++; if (d !== exp[1] || w !== 2) begin bad++; $display("FAIL bp_next: got %h (lat %0d) want %h (lat 2)", d, w, exp[1]); end
        repeat (5) step();
        total++; if (pix_valid !== 1'b1 || pix_data !== exp[1]) begin bad++; $display("FAIL bp_single_xfer: got %h valid %b want %h valid 1", pix_data, pix_valid, exp[1]); end
        pix_ready = 1;
        step();
        for (int k = 2; k < 8; k++) begin
            get_word(d, l, w);
            total++; if (d !== exp[k] || l !== (k == 7)) begin bad++; $display("FAIL bp_data[%0d]: got %h last %b want %h last %b", k, d, l, exp[k], k == 7); end
            step();
        end
    endtask

    task automatic test_pending();
        logic [23:0] exp [8];
        logic [23:0] d; logic l; int w, extra;
        exp = '{24'h64C832, 24'hFF0000, 24'h0000FF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        brightness = 255; pix_ready = 1;
        pulse_req();
        for (int k = 0; k < 8; k++) begin
            get_word(d, l, w);
            total++; if (d !== exp[k]) begin bad++; $display("FAIL pend_f1[%0d]: got %h want %h", k, d, exp[k]); end
            frame_req = (k == 1 || k == 3 || k == 5);
            step();
            frame_req = 0;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pend_busy_boundary: got %b want 1", busy); end
        for (int k = 0; k < 8; k++) begin
            get_word(d, l, w);
            total++; if (d !== exp[k] || w !== 2 || l !== (k == 7)) begin bad++; $display("FAIL pend_f2[%0d]: got %h lat %0d last %b want %h lat 2 last %b", k, d, w, l, exp[k], k == 7); end
            step();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pend_busy_end: got %b want 0", busy); end
        extra = 0;
        repeat (10) begin
            step();
            if (pix_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL pend_no_third: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_hazard();
        logic [23:0] exp1 [8];
        logic [23:0] exp2 [8];
        logic [23:0] d; logic l; int w;
        exp1 = '{24'h64C832, 24'hFF0000, 24'h0000FF, 24'h0, 24'h0, 24'h341256, 24'h0, 24'h0};
        exp2 = '{24'h111111, 24'hFF0000, 24'h0000FF, 24'hCDABEF, 24'h0, 24'h341256, 24'h0, 24'h0};
        brightness = 255; pix_ready = 1;
        pulse_req();
        for (int k = 0; k < 8; k++) begin
            get_word(d, l, w);
            total++; if (d !== exp1[k] || w !== (k == 3 ? 1 : 2)) begin bad++; $display("FAIL hazard_f1[%0d]: got %h lat %0d want %h", k, d, w, exp1[k]); end
            if (k == 0) begin wr_en = 1; wr_addr = 0; wr_rgb = 24'h111111; end
            if (k == 1) begin wr_en = 1; wr_addr = 5; wr_rgb = 24'h123456; end
            step();
            wr_en = 0;
            if (k == 2) wr(3, 24'hABCDEF);
        end
        pulse_req();
        for (int k = 0; k < 8; k++) begin
            get_word(d, l, w);
            total++; if (d !== exp2[k] || w !== 2) begin bad++; $display("FAIL hazard_f2[%0d]: got %h lat %0d want %h", k, d, w, exp2[k]); end
            step();
        end
    endtask

    task automatic test_timer();
        logic [23:0] exp [8];
        logic [23:0] d; logic l; int w, n;
        logic prev;
        int t [3];
        exp = '{24'h111111, 24'hFF0000, 24'h0000FF, 24'hCDABEF, 24'h0, 24'h341256, 24'h0, 24'h0};
        wr(8, 24'h777777);
        wr(9, 24'h777777);
        brightness = 255; pix_ready = 1;
        pulse_req();
        for (int k = 0; k < 8; k++) begin
            get_word(d, l, w);
            total++; if (d !== exp[k] || l !== (k == 7)) begin bad++; $display("FAIL oob_write[%0d]: got %h last %b want %h last %b", k, d, l, exp[k], k == 7); end
            step();
        end
        for (int j = 0; j < 3; j++) begin
            n = 0;
            prev = busy2;
            step();
            while (!(busy2 && !prev) && n < 700) begin
                prev = busy2;
                step();
                n++;
            end
            t[j] = cyc;
        end
        total++; if (t[1] - t[0] !== 300) begin bad++; $display("FAIL timer_period1: got %0d want 300", t[1] - t[0]); end
        total++; if (t[2] - t[1] !== 300) begin bad++; $display("FAIL timer_period2: got %0d want 300", t[2] - t[1]); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] exp [4];
        logic [23:0] d; logic l; int w, act;
        exp = '{24'h111111, 24'hFF0000, 24'h0000FF, 24'hCDABEF};
        brightness = 255; pix_ready = 1;
        pulse_req();
        for (int k = 0; k < 4; k++) begin
            get_word(d, l, w);
            total++; if (d !== exp[k]) begin bad++; $display("FAIL rstmid_pre[%0d]: got %h want %h", k, d, exp[k]); end
            step();
        end
        get_word(d, l, w);
        total++; if (pix_valid !== 1'b1 || w !== 2) begin bad++; $display("FAIL rstmid_present: got valid %b lat %0d want valid 1 lat 2", pix_valid, w); end
        rst_n = 0;
        #1;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", pix_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (pix_data !== 24'h0 || pix_last !== 1'b0) begin bad++; $display("FAIL rstmid_data: got %h last %b want 000000 last 0", pix_data, pix_last); end
        repeat (2) step();
        rst_n = 1;
        act = 0;
        repeat (10) begin
            step();
            if (pix_valid !== 1'b0 || busy !== 1'b0) act++;
        end
        total++; if (act !== 0) begin bad++; $display("FAIL rstmid_idle: got %0d active cycles want 0", act); end
        pulse_req();
        for (int k = 0; k < 8; k++) begin
            get_word(d, l, w);
            total++; if (d !== 24'h0 || w !== 2 || l !== (k == 7)) begin bad++; $display("FAIL rstmid_buf[%0d]: got %h lat %0d last %b want 000000 lat 2 last %b", k, d, w, l, k == 7); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scale();
        test_backpressure();
        test_pending();
        test_hazard();
        test_timer();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
